ifu_fetch: RTL
==============

// Module: ifu_fetch
// PURPOSE
//   Instruction fetch unit feeding the decode stage of the multi-cycle NPC core.
//   Holds the PC and fetches one instruction word per retired instruction over a
//   valid/ready instruction-memory bus, then presents inst/pc to decode with a handshake.
//   Takes the next PC back from the execute/writeback side, and parks on ebreak (halt).
// PARAMETERS
//   RESET_PC  32'h8000_0000  PC loaded on reset; first fetch address
//   XLEN      32             address/data width (only 32 supported)
// PORTS
//   clk             in   1     clock, all state updates on rising edge
//   rst             in   1     synchronous reset, active-high
//   imem_req_valid  out  1     fetch request valid
//   imem_req_ready  in   1     memory accepts request
//   imem_req_addr   out  XLEN  fetch address (= pc)
//   imem_resp_valid in   1     response data valid (single-cycle pulse)
//   imem_resp_data  in   32    fetched instruction word
//   imem_resp_err   in   1     bus error for this response
//   inst_valid      out  1     inst/inst_pc/fetch_err valid to decode
//   inst_ready      in   1     decode consumes instruction
//   inst            out  32    instruction word
//   inst_pc         out  XLEN  PC of inst
//   fetch_err       out  1     inst is invalid: bus error or misaligned PC
//   next_pc_valid   in   1     retiring instruction supplies next PC
//   next_pc         in   XLEN  next PC value
//   halt            in   1     stop request (decode's stop_sim, ebreak retiring)
//   halted          out  1     fetch parked permanently
//   fetch_cnt       out  32    count of instructions handed to decode
// BEHAVIOUR
//   Reset: pc=RESET_PC, state=REQ, inst=0, inst_pc=RESET_PC, fetch_err=0, fetch_cnt=0;
//     during rst all outputs are 0 except imem_req_addr/inst_pc=RESET_PC.
//   FSM states REQ, WAIT, HOLD, EXEC, HALT:
//   REQ : imem_req_valid=1, addr=pc held stable; req_valid stays high until accepted;
//         on imem_req_ready -> WAIT.
//   WAIT: on imem_resp_valid: inst<=resp_data, fetch_err<=resp_err, inst_pc<=pc -> HOLD.
//         Stays in WAIT indefinitely otherwise (no timeout).
//   HOLD: inst_valid=1; inst/inst_pc/fetch_err stable; on inst_ready: fetch_cnt+1 (wraps
//         at 2^32) -> EXEC.
//   EXEC: waits for retirement. halt=1 -> HALT (priority over next_pc_valid, same cycle).
//         Else next_pc_valid=1: pc<=next_pc; if next_pc[1:0]==0 -> REQ;
//         misaligned -> inst<=0, inst_pc<=next_pc, fetch_err<=1 -> HOLD, no bus request.
//   HALT: halted=1, all request/valid outputs 0; exit only by rst.
//   imem_resp_valid outside WAIT, next_pc_valid/halt outside EXEC: ignored.
//   Memory must not return a response in the same cycle the request is accepted.
//   Min latency: REQ accept cycle N, resp at N+1, inst_valid at N+2.
//   Back-to-back: next_pc_valid in cycle M -> imem_req_valid in cycle M+1.
//   rst mid-transaction (any state): return to REQ at RESET_PC; a stale response
//     arriving after reset is ignored, since the FSM is in REQ, not WAIT.
//   One outstanding request max; no prefetch, no speculation.
// TESTING
//   1 reset release, ready=1, resp 1 cyc later data=32'h00100093 -> req addr 80000000,
//     inst_valid 2 cyc after accept, inst=00100093, inst_pc=80000000, fetch_cnt=1 on handshake.
//   2 imem_req_ready low 3 cycles -> req_valid/addr held stable; resp 4 cyc late -> no
//     duplicate request, single inst delivered.
//   3 inst_ready low 5 cycles in HOLD -> inst/inst_pc unchanged; resp_valid pulse there ignored.
//   4 next_pc=80000010 -> next req addr 80000010; next_pc=80000012 -> no req,
//     inst_valid with fetch_err=1, inst=0, inst_pc=80000012.
//   5 resp_err=1 -> fetch_err=1 on delivered inst; halt and next_pc_valid together in
//     EXEC -> HALT, halted=1, no further requests for 20 cycles.
//   6 rst asserted in WAIT, late resp after release -> pc=80000000 refetched, stale data dropped.

Source files
------------

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: holds the PC, issues one imem request per retired instruction,
// and hands each fetched word to decode over a valid/ready handshake; parks on halt.
module ifu_fetch #(
    parameter int unsigned XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    input  logic            imem_resp_err,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            fetch_err,
    input  logic            next_pc_valid,
    input  logic [XLEN-1:0] next_pc,
    input  logic            halt,
    output logic            halted,
    output logic [31:0]     fetch_cnt
);

    localparam logic [2:0] StReq  = 3'd0;
    localparam logic [2:0] StWait = 3'd1;
    localparam logic [2:0] StHold = 3'd2;
    localparam logic [2:0] StExec = 3'd3;
    localparam logic [2:0] StHalt = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     inst_q, inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic            err_q, err_d;
    logic [31:0]     cnt_q, cnt_d;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        case (state_q)
            StReq: begin
                if (imem_req_ready) state_d = StWait;
            end
            StWait: begin
                if (imem_resp_valid) begin
                    inst_d    = imem_resp_data;
                    err_d     = imem_resp_err;
                    inst_pc_d = pc_q;
                    state_d   = StHold;
                end
            end
            StHold: begin
                if (inst_ready) begin
                    cnt_d   = cnt_q + 32'd1;
                    state_d = StExec;
                end
            end
            StExec: begin
                // halt wins over a next PC offered in the same cycle
                if (halt) begin
                    state_d = StHalt;
                end else if (next_pc_valid) begin
                    pc_d = next_pc;
                    if (next_pc[1:0] == 2'b00) begin
                        state_d = StReq;
                    end else begin
                        // misaligned target: report it to decode without touching the bus
                        inst_d    = 32'h0;
                        inst_pc_d = next_pc;
                        err_d     = 1'b1;
                        state_d   = StHold;
                    end
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StReq;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StReq;
            pc_q      <= RESET_PC;
            inst_q    <= 32'h0;
            inst_pc_q <= RESET_PC;
            err_q     <= 1'b0;
            cnt_q     <= 32'h0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    // Outputs are forced to their reset values while rst is high, even before the first edge.
    assign imem_req_valid = ~rst & (state_q == StReq);
    assign imem_req_addr  = rst ? RESET_PC : pc_q;
    assign inst_valid     = ~rst & (state_q == StHold);
    assign inst           = rst ? 32'h0 : inst_q;
    assign inst_pc        = rst ? RESET_PC : inst_pc_q;
    assign fetch_err      = ~rst & err_q;
    assign halted         = ~rst & (state_q == StHalt);
    assign fetch_cnt      = rst ? 32'h0 : cnt_q;

endmodule
